// File: rtl/dac_spi_receiver_if.sv
// dac_spi_receiver_if: bundles the SPI pins, the LDAC strobe and the
// decoded DAC/frame outputs of the laser DAC receiver.
// The master side drives the SPI link and LDAC and observes the outputs;
// the slave side is the receiver itself.
interface dac_spi_receiver_if #(
  parameter int FRAME_BITS = 16
);
  logic                  spi_sclk;
  logic                  spi_csn;
  logic                  spi_mosi;
  logic                  dac_latchn;
  logic [11:0]           dac_a;
  logic [11:0]           dac_b;
  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_valid;
  logic                  frame_err;

  modport master (
    output spi_sclk,
    output spi_csn,
    output spi_mosi,
    output dac_latchn,
    input  dac_a,
    input  dac_b,
    input  frame_data,
    input  frame_valid,
    input  frame_err
  );

  modport slave (
    input  spi_sclk,
    input  spi_csn,
    input  spi_mosi,
    input  dac_latchn,
    output dac_a,
    output dac_b,
    output frame_data,
    output frame_valid,
    output frame_err
  );
endinterface

// File: rtl/dac_spi_receiver.sv
// dac_spi_receiver: oversampling receiver for MCP4922-style 16-bit DAC
// command frames. The SPI pins and LDAC are synchronised into clk, edges
// are detected with one extra flop, and a three-state FSM (IDLE, SHIFT,
// CLOSE) assembles frames into per-channel pending registers. A falling
// LDAC copies both pending registers to the DAC outputs.
// Optional feature macro: DAC_RX_SHDN_EN -- when defined, a valid frame
// with SHDNn = 0 loads zero into its channel instead of the frame's code.
module dac_spi_receiver #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset,
  dac_spi_receiver_if.slave bus
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_MAX   = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CLOSE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] latch_sync;
  logic                   sclk_dly;
  logic                   csn_dly;
  logic                   latch_dly;

  logic sclk_s;
  logic csn_s;
  logic mosi_sync;
  logic latch_s;
  logic sclk_rise;
  logic csn_fall;
  logic csn_rise;
  logic latch_fall;

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [4:0]            bit_cnt;
  logic [11:0]           pend_a;
  logic [11:0]           pend_b;
  logic [11:0]           dac_a_q;
  logic [11:0]           dac_b_q;
  logic [FRAME_BITS-1:0] frame_data_q;
  logic                  frame_valid_q;
  logic                  frame_err_q;
  logic [11:0]           wr_code;

  // Synchroniser chains plus one edge-detect flop; idle levels are the reset values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync   <= '0;
      csn_sync    <= '1;
      mosi_sync_q <= '0;
      latch_sync  <= '1;
      sclk_dly    <= 1'b0;
      csn_dly     <= 1'b1;
      latch_dly   <= 1'b1;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      csn_sync    <= {csn_sync[SYNC_STAGES-2:0], bus.spi_csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      latch_sync  <= {latch_sync[SYNC_STAGES-2:0], bus.dac_latchn};
      sclk_dly    <= sclk_sync[SYNC_STAGES-1];
      csn_dly     <= csn_sync[SYNC_STAGES-1];
      latch_dly   <= latch_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign csn_s      = csn_sync[SYNC_STAGES-1];
  assign mosi_sync  = mosi_sync_q[SYNC_STAGES-1];
  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_dly;
  assign csn_fall   = ~csn_s & csn_dly;
  assign csn_rise   = csn_s & ~csn_dly;
  assign latch_fall = ~latch_s & latch_dly;

  // Code written to the addressed pending register when a frame closes cleanly
  always_comb begin
    wr_code = shreg[11:0];
`ifdef DAC_RX_SHDN_EN
    if (!shreg[12]) begin
      wr_code = 12'd0;
    end
`else
`endif
  end

  // Frame FSM, pending registers and LDAC transfer; the transfer reads the
  // pending values from before any write landing in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      pend_a        <= '0;
      pend_b        <= '0;
      dac_a_q       <= '0;
      dac_b_q       <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (latch_fall) begin
        dac_a_q <= pend_a;
        dac_b_q <= pend_b;
      end
      case (state)
        IDLE: begin
          if (csn_fall) begin
            shreg   <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], mosi_sync};
            if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          if (csn_rise) begin
            state <= CLOSE;
          end
        end
        CLOSE: begin
          state <= IDLE;
          if (bit_cnt == FRAME_CNT) begin
            frame_data_q  <= shreg;
            frame_valid_q <= 1'b1;
            if (shreg[15]) begin
              pend_b <= wr_code;
            end else begin
              pend_a <= wr_code;
            end
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dac_a       = dac_a_q;
  assign bus.dac_b       = dac_b_q;
  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// tb_dac_spi_receiver: directed plus randomised frames against a
// transaction-level model of the DAC receiver (pending/output registers
// updated per whole frame and per latch pulse).
module tb_dac_spi_receiver;

  localparam int SYNC_STAGES = 2;
`ifdef DAC_RX_SHDN_EN
  localparam bit SHDN_EN = 1'b1;
`else
  localparam bit SHDN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int failures = 0;

  int valid_seen = 0;
  int err_seen = 0;
  int overlap_seen = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int valid_lat = 0;

  logic [11:0] m_pend_a = '0;
  logic [11:0] m_pend_b = '0;
  logic [11:0] m_dac_a = '0;
  logic [11:0] m_dac_b = '0;
  logic [15:0] m_frame = '0;
  int          m_valid = 0;
  int          m_err = 0;

  dac_spi_receiver_if bus ();

  dac_spi_receiver #(
    .FRAME_BITS (16),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Cycle counter used to time the frame_valid latency
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      if (bus.frame_valid) begin
        valid_seen <= valid_seen + 1;
        valid_lat  <= cyc - rise_cyc;
      end
      if (bus.frame_err) err_seen <= err_seen + 1;
      if (bus.frame_valid && bus.frame_err) overlap_seen <= overlap_seen + 1;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-frame model: a clean 16-bit frame updates frame_data and one pending register
  task automatic model_frame(input logic [31:0] bits, input int n);
    logic [11:0] code;
    if (n == 16) begin
      m_frame = bits[15:0];
      m_valid++;
      code = (SHDN_EN && !bits[12]) ? 12'd0 : bits[11:0];
      if (bits[15]) m_pend_b = code;
      else m_pend_a = code;
    end else begin
      m_err++;
    end
  endtask

  task automatic model_latch();
    m_dac_a = m_pend_a;
    m_dac_b = m_pend_b;
  endtask

  task automatic model_reset();
    m_pend_a = '0;
    m_pend_b = '0;
    m_dac_a  = '0;
    m_dac_b  = '0;
    m_frame  = '0;
  endtask

  // Sends n bits MSB first; with collide set, LDAC falls one clk after csn rises
  task automatic applyStimulus(input logic [31:0] bits, input int n, input bit collide);
    bus.spi_csn = 1'b0;
    wait_clks(4);
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_mosi = bits[i];
      wait_clks(4);
      bus.spi_sclk = 1'b1;
      wait_clks(4);
      bus.spi_sclk = 1'b0;
    end
    wait_clks(4);
    bus.spi_csn = 1'b1;
    rise_cyc = cyc;
    if (collide) begin
      wait_clks(1);
      bus.dac_latchn = 1'b0;
      wait_clks(4);
      bus.dac_latchn = 1'b1;
      model_latch();
      model_frame(bits, n);
    end else begin
      model_frame(bits, n);
    end
    wait_clks(6);
  endtask

  task automatic pulse_latch();
    bus.dac_latchn = 1'b0;
    wait_clks(5);
    bus.dac_latchn = 1'b1;
    wait_clks(5);
    model_latch();
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, "_dac_a"}, 32'(bus.dac_a), 32'(m_dac_a));
    checkOutput({tag, "_dac_b"}, 32'(bus.dac_b), 32'(m_dac_b));
    checkOutput({tag, "_frame_data"}, 32'(bus.frame_data), 32'(m_frame));
    checkOutput({tag, "_valid_count"}, 32'(valid_seen), 32'(m_valid));
    checkOutput({tag, "_err_count"}, 32'(err_seen), 32'(m_err));
  endtask

  // Directed sequence followed by randomised frames
  initial begin
    logic [31:0] rnd;
    int          len;

    bus.spi_sclk   = 1'b0;
    bus.spi_csn    = 1'b1;
    bus.spi_mosi   = 1'b0;
    bus.dac_latchn = 1'b1;
    reset          = 1'b0;
    wait_clks(3);
    checkOutput("reset_dac_a", 32'(bus.dac_a), 32'h0);
    checkOutput("reset_dac_b", 32'(bus.dac_b), 32'h0);
    checkOutput("reset_frame_data", 32'(bus.frame_data), 32'h0);
    checkOutput("reset_frame_valid", 32'(bus.frame_valid), 32'h0);
    checkOutput("reset_frame_err", 32'(bus.frame_err), 32'h0);
    reset = 1'b1;
    wait_clks(4);

    $display("[TB] frame 0x3ABC then latch");
    applyStimulus(32'h3ABC, 16, 1'b0);
    checkOutput("first_frame_data", 32'(bus.frame_data), 32'h3ABC);
    checkOutput("first_valid_count", 32'(valid_seen), 32'd1);
    checkOutput("first_valid_latency", 32'(valid_lat), 32'(SYNC_STAGES + 2));
    checkOutput("first_dac_a_before_latch", 32'(bus.dac_a), 32'h0);
    pulse_latch();
    checkOutput("first_dac_a", 32'(bus.dac_a), 32'hABC);
    checkOutput("first_dac_b", 32'(bus.dac_b), 32'h0);

    $display("[TB] frame 0xB123, latch later");
    applyStimulus(32'hB123, 16, 1'b0);
    checkOutput("chb_dac_b_held", 32'(bus.dac_b), 32'h0);
    pulse_latch();
    checkOutput("chb_dac_b", 32'(bus.dac_b), 32'h123);
    check_model("chb");

    $display("[TB] short and long frames");
    applyStimulus(32'h0000_7F00, 15, 1'b0);
    applyStimulus(32'h0001_0777, 17, 1'b0);
    pulse_latch();
    checkOutput("badlen_err_count", 32'(err_seen), 32'd2);
    checkOutput("badlen_valid_count", 32'(valid_seen), 32'd2);
    check_model("badlen");

    $display("[TB] latch colliding with frame close");
    applyStimulus(32'h3111, 16, 1'b0);
    pulse_latch();
    applyStimulus(32'h3555, 16, 1'b1);
    checkOutput("collide_dac_a_old", 32'(bus.dac_a), 32'h111);
    pulse_latch();
    checkOutput("collide_dac_a_new", 32'(bus.dac_a), 32'h555);
    check_model("collide");

    $display("[TB] reset in the middle of a frame");
    bus.spi_csn = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 8; i++) begin
      bus.spi_mosi = i[0];
      wait_clks(4);
      bus.spi_sclk = 1'b1;
      wait_clks(4);
      bus.spi_sclk = 1'b0;
    end
    reset = 1'b0;
    wait_clks(2);
    bus.spi_csn = 1'b1;
    bus.spi_mosi = 1'b0;
    model_reset();
    wait_clks(2);
    checkOutput("midreset_dac_a", 32'(bus.dac_a), 32'h0);
    checkOutput("midreset_frame_data", 32'(bus.frame_data), 32'h0);
    reset = 1'b1;
    wait_clks(4);
    applyStimulus(32'h3FFF, 16, 1'b0);
    pulse_latch();
    checkOutput("midreset_dac_a_after", 32'(bus.dac_a), 32'hFFF);
    check_model("midreset");

    $display("[TB] shutdown bit frame 0x2ABC");
    applyStimulus(32'h2ABC, 16, 1'b0);
    pulse_latch();
    check_model("shdn");

    $display("[TB] randomised frames");
    for (int k = 0; k < 10; k++) begin
      rnd = $urandom;
      case ($urandom_range(0, 5))
        0: len = 15;
        1: len = 17;
        2: len = 0;
        default: len = 16;
      endcase
      applyStimulus(rnd, len, 1'b0);
      if ($urandom_range(0, 1) == 1) pulse_latch();
      check_model("rand");
    end
    pulse_latch();
    check_model("final");
    checkOutput("valid_err_overlap", 32'(overlap_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
